vga_timing_gen: RTL



---
 rtl/vga_pkg.sv | 29 ++
 rtl/pix_tick_gen.sv | 30 +++
 rtl/vga_timing_gen.sv | 87 ++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 800x600 @ 72 Hz raster.
// pong_graph reuses SCREEN_W/SCREEN_H for its MAX_X/MAX_Y.
package vga_pkg;

  localparam int   DEF_PIX_DIV  = 2;
  localparam int   DEF_H_DISP   = 800;
  localparam int   DEF_H_FP     = 56;
  localparam int   DEF_H_SYNC   = 120;
  localparam int   DEF_H_BP     = 64;
  localparam int   DEF_V_DISP   = 600;
  localparam int   DEF_V_FP     = 37;
  localparam int   DEF_V_SYNC   = 6;
  localparam int   DEF_V_BP     = 23;
  localparam logic DEF_SYNC_POL = 1'b1;

  localparam int H_TOTAL      = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL      = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_START = DEF_H_DISP + DEF_H_FP;
  localparam int V_SYNC_START = DEF_V_DISP + DEF_V_FP;

  localparam int SCREEN_W = DEF_H_DISP;
  localparam int SCREEN_H = DEF_V_DISP;

  // Half-open window test [lo, hi) used for the sync pulse decode.
  function automatic logic in_window(input int val, input int lo, input int hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel clock-enable divider: p_tick is a registered one-clk pulse
// every PIX_DIV board clocks, first asserted on the PIX_DIV-th edge after reset.
module pix_tick_gen
  import vga_pkg::*;
#(
  parameter int PIX_DIV = DEF_PIX_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic             div_last;

  assign div_last = (int'(div) == PIX_DIV - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div    <= '0;
      p_tick <= 1'b0;
    end else begin
      div    <= div_last ? '0 : div + 1'b1;
      p_tick <= div_last;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters plus registered coordinate,
// video_on, sync and frame_tick outputs, all mutually aligned.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   PIX_DIV  = DEF_PIX_DIV,
  parameter int   H_DISP   = DEF_H_DISP,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_DISP   = DEF_V_DISP,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic        clk,
  input  logic        reset,
  output logic        p_tick,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick
);

  localparam int H_TOT    = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_DISP + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISP + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int H_W      = $clog2(H_TOT);
  localparam int V_W      = $clog2(V_TOT);

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           h_last;
  logic           v_last;

  pix_tick_gen #(
    .PIX_DIV(PIX_DIV)
  ) u_pix_tick (
    .clk   (clk),
    .reset (reset),
    .p_tick(p_tick)
  );

  assign h_last = (int'(h) == H_TOT - 1);
  assign v_last = (int'(v) == V_TOT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (p_tick) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Outputs trail the counters by one clk; frame_tick fires on the step
  // from the last visible line into the first blanking line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_x      <= '0;
      pix_y      <= '0;
      video_on   <= 1'b0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      frame_tick <= 1'b0;
    end else begin
      pix_x      <= 16'(h);
      pix_y      <= 16'(v);
      video_on   <= (int'(h) < H_DISP) && (int'(v) < V_DISP);
      hsync      <= in_window(int'(h), HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync      <= in_window(int'(v), VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      frame_tick <= p_tick && h_last && (int'(v) == V_DISP - 1);
    end
  end

endmodule
